alu_md_control: RTL and testbench

- Next-generation ALU control unit for the MIPS32 core.
- Keeps the combinational ALUOp/funct → ALU_control decode and adds a parametrised iterative multiply/divide unit (MDU) with architectural HI/LO registers.
- Serves MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside the main ALU and raises a stall toward PC/regfile write-enable while a multi-cycle operation runs.

---
 rtl/mips_alu_pkg.sv | 48 ++++
 rtl/md_iter_core.sv | 65 ++++++
 rtl/alu_md_control.sv | 144 ++++++++++++++
 tb/tb_alu_md_control.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS32 ALU control unit and multiply/divide unit.
package mips_alu_pkg;

   localparam int unsigned ALUC_W  = 4;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned FUNCT_W = 6;

   localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;
   localparam logic [ALUC_W-1:0] ALU_INV = 4'b1111;

   localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_INV   = 2'b11;

   localparam logic [FUNCT_W-1:0] F_ADD   = 6'b100000;
   localparam logic [FUNCT_W-1:0] F_SUB   = 6'b100010;
   localparam logic [FUNCT_W-1:0] F_AND   = 6'b100100;
   localparam logic [FUNCT_W-1:0] F_OR    = 6'b100101;
   localparam logic [FUNCT_W-1:0] F_NOR   = 6'b100111;
   localparam logic [FUNCT_W-1:0] F_SLT   = 6'b101010;
   localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
   localparam logic [FUNCT_W-1:0] F_MTHI  = 6'b010001;
   localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
   localparam logic [FUNCT_W-1:0] F_MTLO  = 6'b010011;
   localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
   localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
   localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
   localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_MUL  = 2'b01,
      MD_DIV  = 2'b10,
      MD_FIX  = 2'b11
   } md_state_e;

   // MULT/MULTU/DIV/DIVU share the 0110xx funct prefix
   function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
      return f[FUNCT_W-1:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring divide,
// one bit per step, sharing a 2*XLEN accumulator.
module md_iter_core #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            op_div,
   input  logic            step,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic [CNT_W-1:0]  cnt;
   logic              div_r;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     shifted;
   logic [XLEN+1:0]   diff;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;

   // acc = {partial product | remainder, multiplier | quotient}
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff     = {1'b0, shifted} - {2'b00, opnd};
      if (diff[XLEN+1])
         div_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
         div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         opnd  <= '0;
         cnt   <= '0;
         div_r <= 1'b0;
      end else if (start) begin
         acc   <= {{XLEN{1'b0}}, a};
         opnd  <= b;
         cnt   <= '0;
         div_r <= op_div;
      end else if (step) begin
         acc   <= div_r ? div_next : mul_next;
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // high while the final iteration is being performed
   assign done   = (cnt == CNT_W'(XLEN - 1));
   assign res_hi = acc[2*XLEN-1:XLEN];
   assign res_lo = acc[XLEN-1:0];

endmodule

// File: rtl/alu_md_control.sv
// MIPS32 ALU control decode plus iterative multiply/divide unit owning HI/LO.
module alu_md_control
   import mips_alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic [FUNCT_W-1:0] Function_field,
   input  logic               instr_valid,
   input  logic [XLEN-1:0]    rs_data,
   input  logic [XLEN-1:0]    rt_data,
   output logic [ALUC_W-1:0]  ALU_control,
   output logic               md_stall,
   output logic               md_rd_en,
   output logic [XLEN-1:0]    md_rd_data,
   output logic [XLEN-1:0]    hi_out,
   output logic [XLEN-1:0]    lo_out
);

   md_state_e state, state_nxt;

   logic            is_r, md_op, mf_op, mt_op, signed_op, op_div;
   logic [XLEN-1:0] abs_rs, abs_rt;
   logic            core_start, core_step, core_done;
   logic [XLEN-1:0] core_hi, core_lo;
   logic            neg_res, neg_rem, div_zero, is_div;
   logic [2*XLEN-1:0] prod, prod_neg;
   logic [XLEN-1:0] fix_hi, fix_lo;

   // ALU operation decode
   always_comb begin
      ALU_control = ALU_INV;
      case (ALUOp)
         ALUOP_MEM: ALU_control = ALU_ADD;
         ALUOP_BEQ: ALU_control = ALU_SUB;
         ALUOP_RTYPE: begin
            case (Function_field)
               F_ADD:   ALU_control = ALU_ADD;
               F_SUB:   ALU_control = ALU_SUB;
               F_AND:   ALU_control = ALU_AND;
               F_OR:    ALU_control = ALU_OR;
               F_SLT:   ALU_control = ALU_SLT;
               F_NOR:   ALU_control = ALU_NOR;
               default: ALU_control = ALU_INV;
            endcase
         end
         default: ALU_control = ALU_INV;
      endcase
   end

   // MDU instruction classification and operand magnitudes
   always_comb begin
      is_r      = instr_valid && (ALUOp == ALUOP_RTYPE);
      md_op     = is_r && is_md_funct(Function_field);
      mf_op     = is_r && ((Function_field == F_MFHI) || (Function_field == F_MFLO));
      mt_op     = is_r && ((Function_field == F_MTHI) || (Function_field == F_MTLO));
      signed_op = !Function_field[0];
      op_div    = Function_field[1];
      abs_rs    = (signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
      abs_rt    = (signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;
   end

   assign core_start = (state == MD_IDLE) && md_op;
   assign core_step  = (state == MD_MUL) || (state == MD_DIV);

   md_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (core_start),
      .op_div (op_div),
      .step   (core_step),
      .a      (abs_rs),
      .b      (abs_rt),
      .done   (core_done),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   // gated by rst_n so the stall drops the moment reset asserts
   assign md_stall = rst_n & (core_start | core_step |
                              ((state == MD_FIX) & (mf_op | mt_op)));
   assign md_rd_en   = mf_op;
   assign md_rd_data = (Function_field == F_MFHI) ? hi_out : lo_out;

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (md_op) state_nxt = op_div ? MD_DIV : MD_MUL;
         MD_MUL,
         MD_DIV:  if (core_done) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // sign correction of the unsigned core result
   always_comb begin
      prod     = {core_hi, core_lo};
      prod_neg = -prod;
      fix_hi   = core_hi;
      fix_lo   = core_lo;
      if (is_div) begin
         fix_lo = div_zero ? '1 : (neg_res ? -core_lo : core_lo);
         fix_hi = neg_rem ? -core_hi : core_hi;
      end else if (neg_res) begin
         fix_hi = prod_neg[2*XLEN-1:XLEN];
         fix_lo = prod_neg[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_out   <= '0;
         lo_out   <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         is_div   <= 1'b0;
      end else begin
         if (core_start) begin
            neg_res  <= signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            neg_rem  <= signed_op & rs_data[XLEN-1];
            div_zero <= (rt_data == '0);
            is_div   <= op_div;
         end
         if ((state == MD_IDLE) && mt_op) begin
            if (Function_field == F_MTHI) hi_out <= rs_data;
            else                          lo_out <= rs_data;
         end
         if (state == MD_FIX) begin
            hi_out <= fix_hi;
            lo_out <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_alu_md_control.sv
// Randomised self-checking bench for alu_md_control against an arithmetic model.
module tb_alu_md_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  ALUOp = 2'b00;
   logic [5:0]  Function_field = 6'b000000;
   logic        instr_valid = 1'b0;
   logic [31:0] rs_data = 32'h0;
   logic [31:0] rt_data = 32'h0;
   logic [3:0]  ALU_control;
   logic        md_stall;
   logic        md_rd_en;
   logic [31:0] md_rd_data;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;

   localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
   localparam logic [5:0] DIV  = 6'b011010, DIVU  = 6'b011011;
   localparam logic [5:0] MFHI = 6'b010000, MTHI  = 6'b010001;
   localparam logic [5:0] MFLO = 6'b010010, MTLO  = 6'b010011;

   alu_md_control dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ALUOp          (ALUOp),
      .Function_field (Function_field),
      .instr_valid    (instr_valid),
      .rs_data        (rs_data),
      .rt_data        (rt_data),
      .ALU_control    (ALU_control),
      .md_stall       (md_stall),
      .md_rd_en       (md_rd_en),
      .md_rd_data     (md_rd_data),
      .hi_out         (hi_out),
      .lo_out         (lo_out)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b1111;
      case (f)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         6'b100111: return 4'b1100;
         default:   return 4'b1111;
      endcase
   endfunction

   // HI/LO the architecture defines for each MDU instruction
   task automatic ref_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] hi, output logic [31:0] lo);
      longint      p, q, r;
      logic [63:0] pu;
      if ((f == DIV || f == DIVU) && rt == 32'h0) begin
         hi = rs;
         lo = 32'hFFFF_FFFF;
      end else if (f == MULT) begin
         p  = longint'($signed(rs)) * longint'($signed(rt));
         hi = p[63:32];
         lo = p[31:0];
      end else if (f == MULTU) begin
         pu = {32'h0, rs} * {32'h0, rt};
         hi = pu[63:32];
         lo = pu[31:0];
      end else if (f == DIV) begin
         q  = longint'($signed(rs)) / longint'($signed(rt));
         r  = longint'($signed(rs)) % longint'($signed(rt));
         hi = r[31:0];
         lo = q[31:0];
      end else begin
         hi = rs % rt;
         lo = rs / rt;
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
      ALUOp = op;
      Function_field = f;
      instr_valid = v;
      rs_data = a;
      rt_data = b;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (md_stall !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
         errors++;
         $display("FAIL reset: stall=%b hi=%h lo=%h required 0/0/0", md_stall, hi_out, lo_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_decode;
      logic [1:0] ops [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
      logic [5:0] fs  [6] = '{6'b100000, 6'b100010, 6'b101010, 6'b100111, 6'b100000, 6'b011000};
      logic [3:0] exp [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0010};
      logic [1:0] op;
      logic [5:0] f;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(ops[i], fs[i], 1'b1, $urandom, $urandom);
         #1;
         checks++;
         if (ALU_control !== exp[i] || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL decode_dir%0d: ctrl=%b stall=%b required %b/0", i, ALU_control, md_stall, exp[i]);
         end
      end
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         op = 2'($urandom_range(0, 3));
         f  = 6'($urandom_range(0, 63));
         drive(op, f, 1'b0, $urandom, $urandom);
         #1;
         checks++;
         if (ALU_control !== ref_ctrl(op, f) || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL decode_rnd op=%b f=%b: ctrl=%b stall=%b required %b/0",
                     op, f, ALU_control, md_stall, ref_ctrl(op, f));
         end
      end
      @(negedge clk);
      drive(2'b00, 6'h0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic run_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      int stall_cycles = 0;
      logic [31:0] eh, el;
      ref_md(f, rs, rt, eh, el);
      @(negedge clk);
      drive(2'b10, f, 1'b1, rs, rt);
      #1;
      while (md_stall === 1'b1 && stall_cycles < 100) begin
         stall_cycles++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (stall_cycles != 33) begin
         errors++;
         $display("FAIL md_latency f=%b: stall cycles=%0d required 33", f, stall_cycles);
      end
      checks++;
      if (hi_out !== m_hi || lo_out !== m_lo) begin
         errors++;
         $display("FAIL md_early_update f=%b: hi=%h lo=%h required %h/%h", f, hi_out, lo_out, m_hi, m_lo);
      end
      @(negedge clk);
      drive(2'b00, 6'h0, 1'b0, 32'h0, 32'h0);
      #1;
      checks++;
      if (hi_out !== eh || lo_out !== el) begin
         errors++;
         $display("FAIL md_result f=%b rs=%h rt=%h: hi=%h lo=%h required %h/%h",
                  f, rs, rt, hi_out, lo_out, eh, el);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic test_directed;
      run_md(MULTU, 32'hFFFF_FFFF, 32'h2);
      run_md(DIV,   32'hFFFF_FFF9, 32'h2);
      run_md(DIVU,  32'h1234_5678, 32'h0);
      run_md(MULT,  32'h8000_0000, 32'h8000_0000);
      run_md(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_md(DIV,   32'hFFFF_FF00, 32'h0);
   endtask

   task automatic test_random;
      logic [5:0]  f;
      logic [31:0] a, b;
      for (int i = 0; i < 12; i++) begin
         f = MULT + 6'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_md(f, a, b);
      end
   endtask

   task automatic test_mf_interlock;
      int stall_cycles = 0;
      logic [31:0] a, b, eh, el;
      a = $urandom;
      b = $urandom;
      ref_md(MULT, a, b, eh, el);
      @(negedge clk);
      drive(2'b10, MULT, 1'b1, a, b);
      @(negedge clk);
      drive(2'b10, MFLO, 1'b1, 32'h0, 32'h0);
      #1;
      while (md_stall === 1'b1 && stall_cycles < 100) begin
         stall_cycles++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (stall_cycles != 33) begin
         errors++;
         $display("FAIL mflo_interlock: stall cycles=%0d required 33", stall_cycles);
      end
      checks++;
      if (md_rd_en !== 1'b1 || md_rd_data !== el) begin
         errors++;
         $display("FAIL mflo_value: en=%b data=%h required 1/%h", md_rd_en, md_rd_data, el);
      end
      m_hi = eh;
      m_lo = el;
      @(negedge clk);
      drive(2'b10, MFHI, 1'b1, 32'h0, 32'h0);
      #1;
      checks++;
      if (md_rd_en !== 1'b1 || md_rd_data !== m_hi || md_stall !== 1'b0) begin
         errors++;
         $display("FAIL mfhi_idle: en=%b data=%h stall=%b required 1/%h/0",
                  md_rd_en, md_rd_data, md_stall, m_hi);
      end
   endtask

   task automatic test_mt;
      logic [31:0] v;
      @(negedge clk);
      drive(2'b10, MTHI, 1'b1, 32'hA5A5_A5A5, 32'h0);
      #1;
      checks++;
      if (hi_out !== m_hi || md_stall !== 1'b0) begin
         errors++;
         $display("FAIL mthi_before_edge: hi=%h stall=%b required %h/0", hi_out, md_stall, m_hi);
      end
      @(posedge clk);
      #1;
      drive(2'b00, 6'h0, 1'b0, 32'h0, 32'h0);
      m_hi = 32'hA5A5_A5A5;
      checks++;
      if (hi_out !== m_hi || lo_out !== m_lo) begin
         errors++;
         $display("FAIL mthi: hi=%h lo=%h required %h/%h", hi_out, lo_out, m_hi, m_lo);
      end
      v = $urandom | 32'h1;
      @(negedge clk);
      drive(2'b10, MTLO, 1'b1, v, 32'h0);
      @(negedge clk);
      drive(2'b00, 6'h0, 1'b0, 32'h0, 32'h0);
      m_lo = v;
      checks++;
      if (lo_out !== m_lo || hi_out !== m_hi) begin
         errors++;
         $display("FAIL mtlo: hi=%h lo=%h required %h/%h", hi_out, lo_out, m_hi, m_lo);
      end
   endtask

   task automatic test_reset_mid_div;
      @(negedge clk);
      drive(2'b10, DIV, 1'b1, $urandom, $urandom | 32'h1);
      repeat (11) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (md_stall !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_div: stall=%b hi=%h lo=%h required 0/0/0", md_stall, hi_out, lo_out);
      end
      drive(2'b00, 6'h0, 1'b0, 32'h0, 32'h0);
      m_hi = 32'h0;
      m_lo = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      run_md(MULTU, 32'd3, 32'd5);
   endtask

   initial begin
      test_reset;
      test_decode;
      test_directed;
      test_mt;
      test_mf_interlock;
      test_random;
      test_reset_mid_div;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
